// File: rtl/seri2para_frame.sv
// Serial-to-parallel frame assembler: shift register plus holding register, valid/ready word output.
// Define SERI2PARA_MSB_FIRST_EN to place the first bit of each word in the MSB (default: LSB).
module seri2para_frame #(
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_FRAME = 19200,
  parameter int CNT_W           = $clog2(WORDS_PER_FRAME + 1)
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iSTART,
  input  logic              iBIT,
  input  logic              iBIT_VALID,
  output logic              oBIT_READY,
  output logic [DATA_W-1:0] oWORD,
  output logic              oWORD_VALID,
  input  logic              iWORD_READY,
  output logic [CNT_W-1:0]  oWORD_IDX,
  output logic              oBusy,
  output logic              oFinished
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FRAME_WORDS = CNT_W'(WORDS_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

  stateT             state;
  logic [DATA_W-1:0] shiftReg;
  logic [DATA_W-1:0] nextShift;
  logic [BIT_W-1:0]  bitCnt;
  logic [CNT_W-1:0]  wordsCaptured;
  logic              shiftFull;
  logic              bitAccept;
  logic              wordDone;
  logic              handOff;

`ifdef SERI2PARA_MSB_FIRST_EN
  assign nextShift = {shiftReg[DATA_W-2:0], iBIT};
`else
  assign nextShift = {iBIT, shiftReg[DATA_W-1:1]};
`endif

  assign oBIT_READY = (state == RUN) && !shiftFull && (wordsCaptured < FRAME_WORDS);
  assign oBusy      = (state != IDLE);
  assign bitAccept  = iBIT_VALID && oBIT_READY;
  assign wordDone   = bitAccept && (bitCnt == LAST_BIT);
  assign handOff    = oWORD_VALID && iWORD_READY;

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state         <= IDLE;
      shiftReg      <= '0;
      bitCnt        <= '0;
      wordsCaptured <= '0;
      shiftFull     <= 1'b0;
      oWORD         <= '0;
      oWORD_VALID   <= 1'b0;
      oWORD_IDX     <= '0;
      oFinished     <= 1'b0;
    end else begin
      oFinished <= 1'b0;
      if (state == IDLE) begin
        if (iSTART) begin
          state         <= RUN;
          shiftReg      <= '0;
          bitCnt        <= '0;
          wordsCaptured <= '0;
          shiftFull     <= 1'b0;
          oWORD_IDX     <= '0;
        end
      end else begin
        if (bitAccept) begin
          shiftReg <= nextShift;
          bitCnt   <= wordDone ? '0 : bitCnt + BIT_W'(1);
        end
        if (wordDone)
          wordsCaptured <= wordsCaptured + CNT_W'(1);
        if (handOff)
          oWORD_IDX <= oWORD_IDX + CNT_W'(1);

        // A finished word bypasses the shift register whenever the holding register frees up this edge.
        if (wordDone && (!oWORD_VALID || handOff)) begin
          oWORD       <= nextShift;
          oWORD_VALID <= 1'b1;
        end else if (wordDone) begin
          shiftFull <= 1'b1;
        end else if (handOff) begin
          if (shiftFull) begin
            oWORD     <= shiftReg;
            shiftFull <= 1'b0;
          end else begin
            oWORD_VALID <= 1'b0;
          end
        end

        if ((state == RUN) && wordDone && (wordsCaptured == LAST_WORD))
          state <= DRAIN;
        // With every word captured and the shift register empty, this hand-off is the last word.
        if ((state == DRAIN) && handOff && !shiftFull) begin
          state     <= IDLE;
          oFinished <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seri2para_frame.md
# seri2para_frame

Parametrised serial-to-parallel frame assembler. It collects a camera pixel bitstream into DATA_W-bit words, counts a fixed number of words per frame, and hands each word downstream over a valid/ready handshake toward the flash/SDRAM writer. A holding register sits behind the shift register, so bit capture continues while the consumer stalls. Full-buffer backpressure is applied on the bit side, and a one-cycle completion pulse is issued per frame.

## Interface
Parameters:
- DATA_W, 16, bits per output word (≥2)
- WORDS_PER_FRAME, 19200, words per frame (default = 640*480/16)
- CNT_W, $clog2(WORDS_PER_FRAME+1), word-counter width

Ports:
- iCLK  in  1  clock; all logic on rising edge
- iRST_n  in  1  reset, synchronous, active-low
- iSTART  in  1  start-of-frame request; sampled only in IDLE
- iBIT  in  1  serial pixel bit
- iBIT_VALID  in  1  iBIT is valid this cycle
- oBIT_READY  out  1  block accepts iBIT this cycle
- oWORD  out  DATA_W  assembled word
- oWORD_VALID  out  1  oWORD holds a word
- iWORD_READY  in  1  consumer accepts oWORD
- oWORD_IDX  out  CNT_W  count of words handed off this frame
- oBusy  out  1  state != IDLE
- oFinished  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on iSTART. Clears the bit counter, the word counter, oWORD_IDX and the shift register. iSTART is ignored in RUN and DRAIN.
- Bit accept: iBIT_VALID && oBIT_READY.
- oBIT_READY = (state==RUN) && !shift_full && (words_captured < WORDS_PER_FRAME).
- Each accepted bit shifts into the shift register. Bit order is set by Configuration.
- The bit counter runs 0..DATA_W-1 and wraps to 0 on the DATA_W-th bit, which completes the word and increments words_captured.
- Word completion routing:
  - If the hold register is empty, or is being handed off this cycle, the completed word (including the incoming bit) loads directly into the hold register.
  - Otherwise the word stays in the shift register with shift_full=1.
- Hand-off: oWORD_VALID && iWORD_READY. On hand-off, oWORD_IDX increments and the hold register reloads from the shift register if shift_full=1 (clearing shift_full), else oWORD_VALID drops.
- RUN → DRAIN on the edge where words_captured reaches WORDS_PER_FRAME.
- DRAIN → IDLE on the hand-off of the final word (shift_full=0). oFinished=1 for exactly the following cycle.
- Width rules:
  - Bit counter is $clog2(DATA_W) bits.
  - Counters never exceed WORDS_PER_FRAME.
  - oWORD_IDX equals WORDS_PER_FRAME when oFinished pulses, and holds that value until the next iSTART.

## Timing
- Reset (iRST_n low at an edge): state IDLE; oBIT_READY=0, oWORD=0, oWORD_VALID=0, oWORD_IDX=0, oBusy=0, oFinished=0. Internal counters and shift_full are cleared.
- Reset mid-frame discards the partial word and any held words. No oFinished is issued.
- oBIT_READY is high the cycle after the iSTART edge.
- Latency: oWORD_VALID is high the cycle after the final bit of a word is accepted, when the hold register is free.
- oWORD is stable while oWORD_VALID=1 and iWORD_READY=0.
- Sustained throughput is 1 bit/cycle with iWORD_READY tied high. There are no bubbles at word boundaries.
- Simultaneous events:
  - Word completion on the same edge as a hand-off: the new word loads into the hold register with no gap.
  - Hand-off on the same edge as shift_full: the shift register transfers and oBIT_READY rises the next cycle.
- Both registers full: oBIT_READY=0. iBIT_VALID is ignored with no data loss, because the producer must hold its bit.
- oFinished never overlaps oWORD_VALID=1 for the same frame.

## Configuration
- SERI2PARA_MSB_FIRST_EN defined: the first accepted bit of each word lands in oWORD[DATA_W-1] (left shift, new bit into [0]).
- SERI2PARA_MSB_FIRST_EN undefined: the first accepted bit lands in oWORD[0] (right shift, new bit into [DATA_W-1]).
- All other behaviour is identical.

## Test plan
All scenarios use DATA_W=8, WORDS_PER_FRAME=2.
- Reset/idle: hold iRST_n low 2 cycles, drive iBIT_VALID=1 without iSTART -> all outputs 0, oBIT_READY stays 0.
- Bit order: iSTART, then bits 1,0,1,1,0,0,0,0 with iWORD_READY=1 -> oWORD=8'h0D (macro undefined) or 8'hB0 (macro defined), valid 1 cycle after the 8th bit.
- Full frame streaming: 16 back-to-back bits, iWORD_READY=1 -> two words; oWORD_IDX 0→1→2; oFinished high exactly 1 cycle after the 2nd hand-off; oBusy then 0.
- Backpressure: iWORD_READY=0 for the whole frame -> word 0 held, word 1 completes into the shift register, oBIT_READY=0 after the 16th bit. Raise iWORD_READY -> words handed off in order with no loss; oFinished follows.
- Mid-frame reset: assert iRST_n low after 5 bits of word 1 -> next cycle all outputs 0; a following iSTART plus 16 bits yields a clean 2-word frame.
- iSTART while busy: pulse iSTART during RUN and DRAIN -> no counter clear, frame completes normally with oWORD_IDX=2.
